// File: rtl/ion_pkg.sv
// Shared sizing constants and FSM encoding for the ion-sensor packet serializer.
package ion_pkg;

    localparam int PACKET_WIDTH = 110;
    localparam int BYTE_WIDTH   = 8;
    localparam int NUM_BYTES    = (PACKET_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int PAD_BITS     = NUM_BYTES * BYTE_WIDTH - PACKET_WIDTH;
    localparam int IDX_WIDTH    = $clog2(NUM_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/ion_shift_loader.sv
// Packet shift register: loads a left-zero-padded packet and walks it out MSB-first,
// one byte per advance, tracking which byte is currently presented.
module ion_shift_loader
    import ion_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [PACKET_WIDTH-1:0] load_data_i,
    input  logic                    advance_i,
    output logic [BYTE_WIDTH-1:0]   byte_o,
    output logic                    last_byte_o
);

    localparam int SHIFT_WIDTH = NUM_BYTES * BYTE_WIDTH;

    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;

    // A load always wins over an advance: it is the back-to-back hand-off point.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load_i) begin
            shift_d = {{PAD_BITS{1'b0}}, load_data_i};
            idx_d   = '0;
        end else if (advance_i) begin
            shift_d = {shift_q[SHIFT_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
            idx_d   = idx_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_o      = shift_q[SHIFT_WIDTH-1 -: BYTE_WIDTH];
    assign last_byte_o = (idx_q == IDX_WIDTH'(NUM_BYTES - 1));

endmodule

// File: rtl/ion_packet_serializer.sv
// Serializes strobed 110-bit sensor packets into a valid/ready byte stream with one
// spare packet of buffering, plus throughput/overrun status for the host.
module ion_packet_serializer
    import ion_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pkt_valid,
    input  logic [PACKET_WIDTH-1:0] pkt_data,
    output logic [BYTE_WIDTH-1:0]   byte_out,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clear_overrun,
    output logic [15:0]             packet_count,
    output logic [7:0]              drop_count
);

    state_e                  state_q, state_d;
    logic [PACKET_WIDTH-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             packet_count_q, packet_count_d;
    logic [7:0]              drop_count_q, drop_count_d;

    logic                    sending, transfer, last_byte, last_xfer, drop;
    logic                    load, advance;
    logic [PACKET_WIDTH-1:0] load_data;
    logic [BYTE_WIDTH-1:0]   shift_byte;

    assign sending   = (state_q == SEND);
    assign transfer  = sending & byte_ready;
    assign last_xfer = transfer & last_byte;
    // The last-byte transfer frees a slot, so a packet arriving then is never dropped.
    assign drop      = sending & pkt_valid & ~last_xfer & hold_full_q;
    assign load      = (~sending & pkt_valid) | (last_xfer & (hold_full_q | pkt_valid));
    assign load_data = (sending & hold_full_q) ? hold_q : pkt_data;
    assign advance   = transfer & ~last_byte;

    ion_shift_loader u_loader (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load),
        .load_data_i (load_data),
        .advance_i   (advance),
        .byte_o      (shift_byte),
        .last_byte_o (last_byte)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pkt_valid) state_d = SEND;
            SEND: if (last_xfer && !hold_full_q && !pkt_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_out   = '0;
        case (state_q)
            SEND: begin
                byte_valid = 1'b1;
                byte_out   = shift_byte;
            end
            default: ;
        endcase
        busy = (state_q == SEND) | hold_full_q;
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (sending && pkt_valid && !last_xfer && !hold_full_q) begin
            hold_d      = pkt_data;
            hold_full_d = 1'b1;
        end else if (last_xfer && hold_full_q) begin
            hold_full_d = pkt_valid;
            if (pkt_valid) hold_d = pkt_data;
        end

        overrun_d      = drop ? 1'b1 : (clear_overrun ? 1'b0 : overrun_q);
        packet_count_d = packet_count_q + {15'd0, last_xfer};
        drop_count_d   = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            overrun_q      <= 1'b0;
            packet_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            overrun_q      <= overrun_d;
            packet_count_q <= packet_count_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign overrun      = overrun_q;
    assign packet_count = packet_count_q;
    assign drop_count   = drop_count_q;

endmodule
